// File: rtl/radio86_bus_pkg.sv
// Shared types and constants for the Radio-86 CPU/video RAM arbiter.
package radio86_bus_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        CPU_D = 2'd1,
        VID_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_VID = 1'b1
    } grant_t;

    localparam int DEFAULT_CPU_PACE = 4;
    localparam int PACE_W           = 8;

endpackage

// File: rtl/radio86_cpu_pacer.sv
// CPU pacing counter and eligibility; with CPU_STEP_EN defined it also
// implements halt / single-instruction stepping.
module radio86_cpu_pacer
    import radio86_bus_pkg::*;
#(
    parameter int CPU_PACE = DEFAULT_CPU_PACE
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_ce,
`ifdef CPU_STEP_EN
    input  logic i_halt,
    input  logic i_step,
    input  logic i_m0,
`endif
    output logic o_elig
);

    localparam logic [PACE_W-1:0] PACE_LOAD = PACE_W'(CPU_PACE - 1);

    logic [PACE_W-1:0] r_pace_cnt;
    logic              w_paced;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pace_cnt <= '0;
        end else if (i_ce) begin
            r_pace_cnt <= PACE_LOAD;
        end else if (r_pace_cnt != '0) begin
            r_pace_cnt <= r_pace_cnt - 1'b1;
        end
    end

    // Eligible one clock early so the grant in ARB lands the ce on the pace.
    assign w_paced = (r_pace_cnt <= PACE_W'(1));

`ifdef CPU_STEP_EN
    logic r_step_d;
    logic r_run;
    logic r_seen_body;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_step_d    <= 1'b0;
            r_run       <= 1'b0;
            r_seen_body <= 1'b0;
        end else begin
            r_step_d <= i_step;
            if (i_ce) begin
                if (i_m0 && r_seen_body) begin
                    r_run       <= 1'b0;
                    r_seen_body <= 1'b0;
                end else if (!i_m0) begin
                    r_seen_body <= 1'b1;
                end
            end
            if (i_step && !r_step_d) begin
                r_run       <= 1'b1;
                r_seen_body <= 1'b0;
            end
        end
    end

    assign o_elig = w_paced && (!i_halt || r_run);
`else
    assign o_elig = w_paced;
`endif

endmodule

// File: rtl/radio86_bus_arbiter.sv
// Radio-86 single-port RAM arbiter: CPU (via cpu_ce sequencing) vs video fetch.
// Optional CPU_STEP_EN macro adds cpu_halt / cpu_step / cpu_m0 stepping inputs.
module radio86_bus_arbiter
    import radio86_bus_pkg::*;
#(
    parameter int CPU_PACE = DEFAULT_CPU_PACE,
    parameter int AW       = 16,
    parameter int DW       = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [AW-1:0] cpu_address,
    input  logic [DW-1:0] cpu_out,
    input  logic          cpu_we,
    output logic          cpu_ce,
    output logic [DW-1:0] cpu_in,
`ifdef CPU_STEP_EN
    input  logic          cpu_halt,
    input  logic          cpu_step,
    input  logic          cpu_m0,
`endif
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [DW-1:0] vid_data,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata,
    output arb_state_t    o_dbg_state
);

    // Handshakes: vid_req is a level held (with vid_addr stable) until the
    // one-cycle vid_ack; cpu_ce is a one-cycle pulse per completed CPU slot.

    arb_state_t    r_state;
    arb_state_t    w_next_state;
    grant_t        r_last_grant;
    grant_t        w_grant;
    logic          w_grant_valid;
    logic          w_cpu_elig;
    logic [DW-1:0] r_cpu_hold;
    logic [DW-1:0] r_vid_data;

    radio86_cpu_pacer #(
        .CPU_PACE (CPU_PACE)
    ) u_pacer (
        .clock   (clock),
        .reset_n (reset_n),
        .i_ce    (cpu_ce),
`ifdef CPU_STEP_EN
        .i_halt  (cpu_halt),
        .i_step  (cpu_step),
        .i_m0    (cpu_m0),
`endif
        .o_elig  (w_cpu_elig)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ARB;
            r_last_grant <= GNT_VID;
            r_cpu_hold   <= '0;
            r_vid_data   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_valid) begin
                r_last_grant <= w_grant;
            end
            if (r_state == CPU_D) begin
                r_cpu_hold <= ram_rdata;
            end
            if (r_state == VID_D) begin
                r_vid_data <= ram_rdata;
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_grant       = r_last_grant;
        w_grant_valid = 1'b0;
        ram_address   = cpu_address;
        ram_wdata     = cpu_out;
        ram_we        = 1'b0;
        cpu_ce        = 1'b0;
        cpu_in        = r_cpu_hold;
        vid_ack       = 1'b0;
        vid_data      = r_vid_data;

        case (r_state)
            ARB: begin
                if (w_cpu_elig && vid_req) begin
                    w_grant_valid = 1'b1;
                    w_grant       = (r_last_grant == GNT_VID) ? GNT_CPU : GNT_VID;
                end else if (w_cpu_elig) begin
                    w_grant_valid = 1'b1;
                    w_grant       = GNT_CPU;
                end else if (vid_req) begin
                    w_grant_valid = 1'b1;
                    w_grant       = GNT_VID;
                end

                if (w_grant_valid) begin
                    if (w_grant == GNT_CPU) begin
                        ram_we       = cpu_we;
                        w_next_state = CPU_D;
                    end else begin
                        ram_address  = vid_addr;
                        w_next_state = VID_D;
                    end
                end
            end
            CPU_D: begin
                cpu_ce       = 1'b1;
                cpu_in       = ram_rdata;
                w_next_state = ARB;
            end
            VID_D: begin
                vid_ack      = 1'b1;
                vid_data     = ram_rdata;
                w_next_state = ARB;
            end
            default: begin
                w_next_state = ARB;
            end
        endcase
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_radio86_bus_arbiter.sv
// Directed bench for radio86_bus_arbiter: two instances (CPU_PACE=2 and 10)
// each with its own synchronous-read RAM model.
module tb_radio86_bus_arbiter;
    import radio86_bus_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    // ---------------- shared stimulus ----------------
    logic [15:0] cpu_address = 16'hF800;
    logic [7:0]  cpu_out = 8'h00;
    logic        cpu_we = 1'b0;
    logic        vid_req = 1'b0;
    logic [15:0] vid_addr = 16'h1234;
    logic        cpu_halt = 1'b0;
    logic        cpu_step = 1'b0;
    logic        cpu_m0 = 1'b0;

    // backdoor preload port into both RAM models
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = 16'h0000;
    logic [7:0]  pl_data2 = 8'h00;
    logic [7:0]  pl_data10 = 8'h00;

    // ---------------- DUT (CPU_PACE=2) ----------------
    logic        ce2, ack2, rwe2;
    logic [7:0]  in2, vdata2, rwd2, rrd2;
    logic [15:0] raddr2;
    arb_state_t  st2;
    logic [7:0]  mem2 [0:65535];

    radio86_bus_arbiter #(.CPU_PACE(2), .AW(16), .DW(8)) dut2 (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_address (cpu_address),
        .cpu_out     (cpu_out),
        .cpu_we      (cpu_we),
        .cpu_ce      (ce2),
        .cpu_in      (in2),
`ifdef CPU_STEP_EN
        .cpu_halt    (cpu_halt),
        .cpu_step    (cpu_step),
        .cpu_m0      (cpu_m0),
`endif
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_ack     (ack2),
        .vid_data    (vdata2),
        .ram_address (raddr2),
        .ram_wdata   (rwd2),
        .ram_we      (rwe2),
        .ram_rdata   (rrd2),
        .o_dbg_state (st2)
    );

    always @(posedge clock) begin
        if (pl_en) mem2[pl_addr] <= pl_data2;
        else if (rwe2) mem2[raddr2] <= rwd2;
        rrd2 <= mem2[raddr2];
    end

    // ---------------- DUT (CPU_PACE=10) ----------------
    logic        ce10, ack10, rwe10;
    logic [7:0]  in10, vdata10, rwd10, rrd10;
    logic [15:0] raddr10;
    arb_state_t  st10;
    logic [7:0]  mem10 [0:65535];

    radio86_bus_arbiter #(.CPU_PACE(10), .AW(16), .DW(8)) dut10 (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_address (cpu_address),
        .cpu_out     (cpu_out),
        .cpu_we      (cpu_we),
        .cpu_ce      (ce10),
        .cpu_in      (in10),
`ifdef CPU_STEP_EN
        .cpu_halt    (cpu_halt),
        .cpu_step    (cpu_step),
        .cpu_m0      (cpu_m0),
`endif
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_ack     (ack10),
        .vid_data    (vdata10),
        .ram_address (raddr10),
        .ram_wdata   (rwd10),
        .ram_we      (rwe10),
        .ram_rdata   (rrd10),
        .o_dbg_state (st10)
    );

    always @(posedge clock) begin
        if (pl_en) mem10[pl_addr] <= pl_data10;
        else if (rwe10) mem10[raddr10] <= rwd10;
        rrd10 <= mem10[raddr10];
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [15:0] a, input logic [7:0] d2, input logic [7:0] d10);
        @(negedge clock);
        pl_en = 1'b1; pl_addr = a; pl_data2 = d2; pl_data10 = d10;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    // Leaves the bench at a negedge with reset just released (state ARB).
    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic next_cyc();
        @(negedge clock);
        #1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int cnt;
        int k;

        reset_n = 1'b0;
        preload(16'hF800, 8'h31, 8'h31);
        preload(16'h1234, 8'hA7, 8'h3C);

        // reset values
        #1;
        chk("rst_ce", ce2, 0);
        chk("rst_ack", ack2, 0);
        chk("rst_we", rwe2, 0);
        chk("rst_vdata", vdata2, 0);
        chk("rst_cpu_in", in2, 0);
        chk("rst_state", st2, ARB);

        // CPU only, pace 2: ce on every other cycle, read data 0x31
        cpu_address = 16'hF800; vid_req = 1'b0; cpu_we = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) next_cyc();
            chk($sformatf("t1_ce[%0d]", i), ce2, (i % 2 == 1));
            chk($sformatf("t1_ack[%0d]", i), ack2, 0);
            if (i % 2 == 1) chk($sformatf("t1_cpu_in[%0d]", i), in2, 8'h31);
            else begin
                chk($sformatf("t1_addr[%0d]", i), raddr2, 16'hF800);
                chk($sformatf("t1_hold[%0d]", i), in2, (i == 0) ? 8'h00 : 8'h31);
            end
        end

        // CPU and video both continuous, pace 2: strict alternation
        vid_req = 1'b1;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i > 0) next_cyc();
            chk($sformatf("t2_ce[%0d]", i), ce2, (i % 4 == 1));
            chk($sformatf("t2_ack[%0d]", i), ack2, (i % 4 == 3));
            if (i % 4 == 2) chk($sformatf("t2_vaddr[%0d]", i), raddr2, 16'h1234);
            if (i % 4 == 3) chk($sformatf("t2_vdata[%0d]", i), vdata2, 8'hA7);
            if (i % 4 == 0) chk($sformatf("t2_vhold[%0d]", i), vdata2, (i == 0) ? 8'h00 : 8'hA7);
        end

        // single CPU write then read back
        vid_req = 1'b0; cpu_address = 16'h7600; cpu_out = 8'h5A; cpu_we = 1'b1;
        do_reset();
        cnt = 0;
        chk("t3_we0", rwe2, 1);
        chk("t3_addr0", raddr2, 16'h7600);
        chk("t3_wdata0", rwd2, 8'h5A);
        cnt += int'(rwe2);
        next_cyc();
        chk("t3_ce1", ce2, 1);
        cnt += int'(rwe2);
        @(posedge clock);
        #1 cpu_we = 1'b0;
        next_cyc();
        chk("t3_addr2", raddr2, 16'h7600);
        cnt += int'(rwe2);
        next_cyc();
        chk("t3_ce3", ce2, 1);
        chk("t3_readback", in2, 8'h5A);
        cnt += int'(rwe2);
        chk("t3_we_count", cnt, 1);

        // pace 10 with continuous video: ce every 10, video fills the gaps
        cpu_address = 16'hF800; vid_req = 1'b1;
        exp_q.delete();
        repeat (9) exp_q.push_back(8'h3C);
        do_reset();
        for (int i = 0; i < 25; i++) begin
            if (i > 0) next_cyc();
            chk($sformatf("t4_ce[%0d]", i), ce10, (i % 10 == 1));
            chk($sformatf("t4_ack[%0d]", i), ack10, (i >= 3 && i % 2 == 1 && i % 10 != 1));
            chk($sformatf("t4_state[%0d]", i), (st10 == ARB), (i % 2 == 0));
            if (ack10 && exp_q.size() > 0) chk($sformatf("t4_vdata[%0d]", i), vdata10, exp_q.pop_front());
        end
        chk("t4_exp_q_empty", exp_q.size(), 0);

        // asynchronous reset during VID_D
        vid_req = 1'b1;
        do_reset();
        next_cyc();
        chk("t5_ce1", ce2, 1);
        next_cyc();
        chk("t5_vaddr2", raddr2, 16'h1234);
        @(posedge clock);
        #2 reset_n = 1'b0;
        next_cyc();
        chk("t5_ack_in_reset", ack2, 0);
        chk("t5_state_in_reset", st2, ARB);
        chk("t5_vdata_in_reset", vdata2, 0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("t5_cpu_wins_addr", raddr2, 16'hF800);
        next_cyc();
        chk("t5_cpu_wins_ce", ce2, 1);
        chk("t5_no_ack", ack2, 0);

`ifdef CPU_STEP_EN
        // halted CPU: one step pulse runs one 4-step instruction
        vid_req = 1'b0; cpu_halt = 1'b1; cpu_step = 1'b0; cpu_m0 = 1'b0;
        do_reset();
        cnt = 0;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            next_cyc();
            cnt += int'(ce2);
        end
        chk("t6_halted", cnt, 0);
        for (int run = 0; run < 2; run++) begin
            cpu_step = 1'b1;
            cnt = 0;
            for (int i = 0; i < 30; i++) begin
                next_cyc();
                cpu_step = 1'b0;
                if (ce2) begin
                    cnt++;
                    k++;
                    cpu_m0 = (k % 4 == 3);
                end
            end
            chk($sformatf("t6_step_ce[%0d]", run), cnt, 4);
        end
        cpu_halt = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
